pixel_array_ctrl: RTL and testbench
===================================

# pixel_array_ctrl

Frame sequencer and readout engine for the pixel array. On a start pulse it runs one exposure: erase, expose, convert, read. During convert it drives the 8-bit digital ramp code that the pixels latch, and during read it drives the per-row read strobes. It then returns the latched row data as a byte stream with a valid/ready handshake. It sits between the pixel array (whose anaReset/erase/expose/anaRamp/read inputs it drives and whose pixData bus it receives) and the downstream frame buffer.

## Interface
- ROWS, 2, number of pixel rows (read strobes)
- COLS, 2, pixels per row (bytes on pixData)
- ERASE_CYCLES, 5, cycles erase is held high (1..65535)
- EXPOSE_CYCLES, 255, cycles expose is held high (1..65535)
- CONVERT_CYCLES, 255, cycles anaRamp is held high (1..256)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin one frame; sampled only in IDLE
- anaReset  output  1  pixel analog reset enable
- erase  output  1  pixel erase phase
- expose  output  1  pixel expose phase
- anaRamp  output  1  ramp/convert phase
- count  output  8  digital ramp code presented to pixels during convert
- read  output  ROWS  one-hot row read strobe
- pixData  input  COLS*8  row data from array, column c at bits [8c+7:8c]
- out_data  output  8  pixel byte
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts byte
- busy  output  1  high in any state other than IDLE
- frame_done  output  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, RD_SEL, RD_CAP, RD_OUT, DONE.
- IDLE: all phase outputs 0, busy=0. start=1 -> ERASE.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles -> EXPOSE.
- EXPOSE: expose=1 for exactly EXPOSE_CYCLES cycles -> CONVERT.
- CONVERT: anaRamp=1 for CONVERT_CYCLES cycles. count = 0 on first cycle, +1 each cycle, so last value = CONVERT_CYCLES-1 (8-bit, never wraps). Leaving CONVERT sets count to 0. The row index r is set to 0 -> RD_SEL.
- RD_SEL: read[r]=1 for one settle cycle -> RD_CAP.
- RD_CAP: read[r] stays 1; pixData is registered into the row buffer at the end of this cycle -> RD_OUT. read returns to 0.
- RD_OUT: bytes are streamed for column 0 up to COLS-1, column 0 first.
  - Acceptance of the last column with r<ROWS-1: r+1 -> RD_SEL.
  - Acceptance of the last column with r=ROWS-1 -> DONE.
- DONE: frame_done=1 for one cycle -> IDLE.
- anaReset=1 in every state after reset release. It is 0 only while reset is asserted.
- At most one of erase/expose/anaRamp/read is active in any cycle. read is always one-hot or zero.
- start outside IDLE is ignored and never queued.
- Duration counters are 16 bits. Column and row indices are sized with $clog2, minimum 1 bit.

## Timing
- Reset values: anaReset=0, erase=0, expose=0, anaRamp=0, count=0, read=0, out_data=0, out_valid=0, busy=0, frame_done=0, state IDLE.
- Reset asserted mid-frame returns every output and the state to these values immediately (asynchronous). The partial frame is discarded.
- All outputs are registered. If start is seen high at edge N, erase and busy are 1 from edge N+1.
- Phase lengths are exact. Boundaries are back-to-back with no gap cycles between ERASE, EXPOSE and CONVERT.
- Per row: 1 RD_SEL + 1 RD_CAP cycle, then at least COLS cycles of RD_OUT. The first out_valid is the cycle after RD_CAP.
- Handshake: a transfer occurs on an edge where out_valid & out_ready. Once raised, out_valid and out_data hold stable until accepted.
- Back-to-back transfers run at 1 byte/cycle within a row. out_valid drops between rows for 2 cycles.
- out_ready high before out_valid is legal and has no effect.
- Minimum frame length: 1 + ERASE + EXPOSE + CONVERT + ROWS*(2+COLS) + 1 cycles, with out_ready held at 1.

## Test plan
- Reset/idle: reset high, then low, start=0 -> every output at its reset value except anaReset=1, and read=0 for 50 cycles.
- Nominal frame, defaults, out_ready=1:
  - start for 1 cycle -> erase high exactly 5 cycles, expose 255, anaRamp 255.
  - count steps 0..254 then 0.
  - read sequence 01 (2 cycles), then 10 (2 cycles).
  - pixData=16'hB7A5 for row 0 and 16'h3C21 for row 1 -> bytes A5, B7, 21, 3C.
  - frame_done pulse at cycle 523 after start.
- Backpressure: out_ready low for 7 cycles on the first byte, then toggling 1/0 -> each byte is held stable while unaccepted. Stream is still A5, B7, 21, 3C with no duplicates or drops.
- start during busy: pulse start during EXPOSE and during RD_OUT -> no effect on phase lengths. Exactly one frame_done is produced, and the controller is in IDLE afterwards.
- Reset mid-operation:
  - Assert reset halfway through CONVERT (count≈127) -> count=0, anaRamp=0, busy=0 at once.
  - A following start yields a full clean frame.
- Parameter sweep with ROWS=3, COLS=4, ERASE=1, EXPOSE=1, CONVERT=256:
  - count reaches 255 without wrap.
  - 12 bytes out in row-major, column-0-first order.
  - read strobes 001, 010, 100.

Source files
------------

// File: rtl/pixel_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pixel_array_ctrl
// Purpose  : Frame sequencer (erase/expose/convert) and row readout engine
//            that streams latched pixel bytes over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module pixel_array_ctrl #(
  parameter int ROWS           = 2,
  parameter int COLS           = 2,
  parameter int ERASE_CYCLES   = 5,
  parameter int EXPOSE_CYCLES  = 255,
  parameter int CONVERT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 anaReset,
  output logic                 erase,
  output logic                 expose,
  output logic                 anaRamp,
  output logic [7:0]           count,
  output logic [ROWS-1:0]      read,
  input  logic [COLS*8-1:0]    pixData,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [15:0]     ERASE_LAST   = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0]     EXPOSE_LAST  = 16'(EXPOSE_CYCLES - 1);
  localparam logic [15:0]     CONVERT_LAST = 16'(CONVERT_CYCLES - 1);
  localparam logic [RW-1:0]   ROW_LAST     = RW'(ROWS - 1);
  localparam logic [CW-1:0]   COL_LAST     = CW'(COLS - 1);
  localparam logic [ROWS-1:0] READ_ROW0    = ROWS'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_RD_SEL  = 3'd4,
    S_RD_CAP  = 3'd5,
    S_RD_OUT  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t             state_q;
  logic [15:0]        dur_q;
  logic [RW-1:0]      row_q;
  logic [CW-1:0]      col_q;
  logic [COLS*8-1:0]  rowbuf_q;
  logic               anaReset_q;
  logic               erase_q;
  logic               expose_q;
  logic               anaRamp_q;
  logic [7:0]         count_q;
  logic [ROWS-1:0]    read_q;
  logic [7:0]         out_data_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               frame_done_q;

  logic [CW-1:0]      col_d;
  logic [RW-1:0]      row_d;

  assign col_d = col_q + CW'(1);
  assign row_d = row_q + RW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      dur_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      rowbuf_q     <= '0;
      anaReset_q   <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      anaRamp_q    <= 1'b0;
      count_q      <= '0;
      read_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      anaReset_q   <= 1'b1;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_ERASE;
            erase_q <= 1'b1;
            busy_q  <= 1'b1;
            dur_q   <= '0;
          end
        end
        S_ERASE: begin
          if (dur_q == ERASE_LAST) begin
            state_q  <= S_EXPOSE;
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
            dur_q    <= '0;
          end else begin
            dur_q <= dur_q + 16'd1;
          end
        end
        S_EXPOSE: begin
          if (dur_q == EXPOSE_LAST) begin
            state_q   <= S_CONVERT;
            expose_q  <= 1'b0;
            anaRamp_q <= 1'b1;
            count_q   <= '0;
            dur_q     <= '0;
          end else begin
            dur_q <= dur_q + 16'd1;
          end
        end
        S_CONVERT: begin
          // Ramp code tracks the cycle index; 256 cycles tops out at 255.
          if (dur_q == CONVERT_LAST) begin
            state_q   <= S_RD_SEL;
            anaRamp_q <= 1'b0;
            count_q   <= '0;
            row_q     <= '0;
            read_q    <= READ_ROW0;
          end else begin
            dur_q   <= dur_q + 16'd1;
            count_q <= count_q + 8'd1;
          end
        end
        S_RD_SEL: begin
          state_q <= S_RD_CAP;
        end
        S_RD_CAP: begin
          rowbuf_q    <= pixData;
          out_data_q  <= pixData[7:0];
          out_valid_q <= 1'b1;
          col_q       <= '0;
          read_q      <= '0;
          state_q     <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (out_valid_q && out_ready) begin
            if (col_q == COL_LAST) begin
              out_valid_q <= 1'b0;
              if (row_q == ROW_LAST) begin
                state_q      <= S_DONE;
                frame_done_q <= 1'b1;
              end else begin
                row_q   <= row_d;
                read_q  <= READ_ROW0 << row_d;
                state_q <= S_RD_SEL;
              end
            end else begin
              col_q      <= col_d;
              out_data_q <= rowbuf_q[{col_d, 3'b000} +: 8];
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign anaReset   = anaReset_q;
  assign erase      = erase_q;
  assign expose     = expose_q;
  assign anaRamp    = anaRamp_q;
  assign count      = count_q;
  assign read       = read_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_array_ctrl
// Purpose  : Directed frames with a byte scoreboard; dut_a uses the default
//            geometry, dut_b a 3x4 array with short phases and a full ramp.
// Revision : 1.0  initial release
// ============================================================================
module tb_pixel_array_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, b_rst, a_start, b_start, out_ready;
  logic [15:0] a_row [2];
  logic [31:0] b_row [3];
  logic [15:0] a_pix;
  logic [31:0] b_pix;

  logic       a_anaReset, a_erase, a_expose, a_anaRamp, a_valid, a_busy, a_done;
  logic [7:0] a_count, a_data;
  logic [1:0] a_read;
  logic       b_anaReset, b_erase, b_expose, b_anaRamp, b_valid, b_busy, b_done;
  logic [7:0] b_count, b_data;
  logic [2:0] b_read;

  // Pixel array model: the strobed row drives its bytes onto pixData.
  assign a_pix = a_read[0] ? a_row[0] : (a_read[1] ? a_row[1] : 16'h0);
  assign b_pix = b_read[0] ? b_row[0] : (b_read[1] ? b_row[1] :
                 (b_read[2] ? b_row[2] : 32'h0));

  pixel_array_ctrl dut_a (
    .clk(clk), .reset(a_rst), .start(a_start), .anaReset(a_anaReset),
    .erase(a_erase), .expose(a_expose), .anaRamp(a_anaRamp), .count(a_count),
    .read(a_read), .pixData(a_pix), .out_data(a_data), .out_valid(a_valid),
    .out_ready(out_ready), .busy(a_busy), .frame_done(a_done)
  );

  pixel_array_ctrl #(
    .ROWS(3), .COLS(4), .ERASE_CYCLES(1), .EXPOSE_CYCLES(1), .CONVERT_CYCLES(256)
  ) dut_b (
    .clk(clk), .reset(b_rst), .start(b_start), .anaReset(b_anaReset),
    .erase(b_erase), .expose(b_expose), .anaRamp(b_anaRamp), .count(b_count),
    .read(b_read), .pixData(b_pix), .out_data(b_data), .out_valid(b_valid),
    .out_ready(out_ready), .busy(b_busy), .frame_done(b_done)
  );

  logic       sel;
  logic       m_erase, m_expose, m_ramp, m_valid, m_done;
  logic [7:0] m_count, m_data, m_read;
  assign m_erase  = sel ? b_erase   : a_erase;
  assign m_expose = sel ? b_expose  : a_expose;
  assign m_ramp   = sel ? b_anaRamp : a_anaRamp;
  assign m_valid  = sel ? b_valid   : a_valid;
  assign m_done   = sel ? b_done    : a_done;
  assign m_count  = sel ? b_count   : a_count;
  assign m_data   = sel ? b_data    : a_data;
  assign m_read   = sel ? {5'b0, b_read} : {6'b0, a_read};

  int          checks, errors;
  logic [7:0]  sb [$];
  int          cyc_n, n_er, n_ex, n_ramp, n_done, er_at, done_at;
  int          bad_excl, bad_cnt, bad_hold, max_cnt, ramp_i, bad;
  logic [31:0] rdsig;
  int          bp_mode, bp_cnt;
  logic        hold_pend;
  logic [7:0]  hold_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cyc_n = 0; n_er = 0; n_ex = 0; n_ramp = 0; n_done = 0; er_at = -1; done_at = -1;
    bad_excl = 0; bad_cnt = 0; bad_hold = 0; max_cnt = 0; ramp_i = 0; rdsig = '0;
  endtask

  task automatic set_rows_a(input logic [15:0] r0, input logic [15:0] r1);
    a_row[0] = r0;
    a_row[1] = r1;
    sb.push_back(r0[7:0]); sb.push_back(r0[15:8]);
    sb.push_back(r1[7:0]); sb.push_back(r1[15:8]);
  endtask

  task automatic set_rows_b(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2);
    b_row[0] = r0; b_row[1] = r1; b_row[2] = r2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        sb.push_back(b_row[r][8*c +: 8]);
  endtask

  // One clock: drive ready, score any transfer at the coming edge, then
  // sample the monitored DUT 1ns after the edge.
  task automatic cyc();
    logic [7:0] e;
    if (bp_mode == 1) begin
      if (bp_cnt < 7) begin
        out_ready = 1'b0;
        if (m_valid) bp_cnt++;
      end else begin
        out_ready = ~out_ready;
      end
    end else begin
      out_ready = 1'b1;
    end
    hold_pend = 1'b0;
    if (m_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("byte", m_data, e);
      end
    end else if (m_valid) begin
      hold_pend = 1'b1;
      hold_val  = m_data;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (hold_pend && !(m_valid && m_data === hold_val)) bad_hold++;
    n_er   += int'(m_erase);
    n_ex   += int'(m_expose);
    n_ramp += int'(m_ramp);
    if (m_erase && er_at < 0) er_at = cyc_n;
    if (m_done) begin
      n_done++;
      done_at = cyc_n;
    end
    if ((int'(m_erase) + int'(m_expose) + int'(m_ramp) + int'(m_read != 8'd0)) > 1 ||
        $countones(m_read) > 1) bad_excl++;
    if (m_ramp) begin
      if (m_count != 8'(ramp_i)) bad_cnt++;
      if (int'(m_count) > max_cnt) max_cnt = int'(m_count);
      ramp_i++;
    end else if (m_count != 8'd0) begin
      bad_cnt++;
    end
    if (m_read != 8'd0) rdsig = {rdsig[27:0], m_read[3:0]};
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = n_done;
    for (int i = 0; i < budget && n_done == d0; i++) cyc();
    chk("done_timeout", 64'(n_done - d0), 64'd1);
  endtask

  initial begin
    checks = 0; errors = 0; sel = 1'b0; bp_mode = 0; bp_cnt = 0; out_ready = 1'b1;
    a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0; hold_pend = 1'b0;
    hold_val = '0;
    a_row[0] = '0; a_row[1] = '0;
    b_row[0] = '0; b_row[1] = '0; b_row[2] = '0;
    clr();

    // Reset values while reset is held
    #2;
    chk("reset_a", {a_anaReset, a_erase, a_expose, a_anaRamp, a_count, a_read,
                    a_data, a_valid, a_busy, a_done}, 64'd0);
    chk("reset_b", {b_anaReset, b_erase, b_expose, b_anaRamp, b_count, b_read,
                    b_data, b_valid, b_busy, b_done}, 64'd0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;

    // Idle for 50 cycles: only anaReset is high
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if ({a_anaReset, a_erase, a_expose, a_anaRamp, a_count, a_read, a_data,
           a_valid, a_busy, a_done} !== 25'h1000000) bad++;
    end
    chk("idle_50", bad, 0);

    // Nominal frame
    set_rows_a(16'hB7A5, 16'h3C21);
    clr();
    a_start = 1'b1; cyc(); a_start = 1'b0;
    chk("start_busy", {a_erase, a_busy}, 2'b11);
    wait_done(1200);
    chk("nom_erase", n_er, 5);
    chk("nom_expose", n_ex, 255);
    chk("nom_ramp", n_ramp, 255);
    chk("nom_count_seq", bad_cnt, 0);
    chk("nom_count_max", max_cnt, 254);
    chk("nom_read_seq", rdsig, 32'h1122);
    chk("nom_latency", done_at - er_at, 523);
    chk("nom_exclusive", bad_excl, 0);
    chk("nom_sb_empty", sb.size(), 0);
    cyc();
    chk("nom_idle", {a_busy, a_done, a_valid, a_anaReset}, 4'b0001);

    // Backpressure: ready low 7 valid cycles, then toggling
    set_rows_a(16'hB7A5, 16'h3C21);
    clr();
    bp_mode = 1; bp_cnt = 0;
    a_start = 1'b1; cyc(); a_start = 1'b0;
    wait_done(2000);
    bp_mode = 0;
    chk("bp_hold", bad_hold, 0);
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_one_done", n_done, 1);

    // start while busy (EXPOSE and RD_OUT) is ignored
    set_rows_a(16'h5A0F, 16'hC3E1);
    clr();
    a_start = 1'b1; cyc(); a_start = 1'b0;
    for (int i = 0; i < 100 && !m_expose; i++) cyc();
    a_start = 1'b1; cyc(); a_start = 1'b0;
    for (int i = 0; i < 1000 && !m_valid; i++) cyc();
    a_start = 1'b1; cyc(); a_start = 1'b0;
    wait_done(1000);
    for (int i = 0; i < 20; i++) cyc();
    chk("busy_start_done", n_done, 1);
    chk("busy_start_erase", n_er, 5);
    chk("busy_start_expose", n_ex, 255);
    chk("busy_start_ramp", n_ramp, 255);
    chk("busy_start_idle", a_busy, 1'b0);
    chk("busy_start_sb", sb.size(), 0);

    // Asynchronous reset halfway through CONVERT
    set_rows_a(16'h1111, 16'h2222);
    clr();
    a_start = 1'b1; cyc(); a_start = 1'b0;
    for (int i = 0; i < 2000 && !(m_ramp && m_count == 8'd127); i++) cyc();
    chk("mid_reached", {m_ramp, m_count}, {1'b1, 8'd127});
    a_rst = 1'b1;
    #1;
    chk("mid_rst", {a_count, a_anaRamp, a_busy, a_read, a_valid, a_anaReset,
                    a_erase, a_expose}, 64'd0);
    cyc();
    a_rst = 1'b0;
    sb.delete();

    // Clean frame after the aborted one
    set_rows_a(16'hB7A5, 16'h3C21);
    clr();
    a_start = 1'b1; cyc(); a_start = 1'b0;
    wait_done(1200);
    chk("post_erase", n_er, 5);
    chk("post_expose", n_ex, 255);
    chk("post_ramp", n_ramp, 255);
    chk("post_count_max", max_cnt, 254);
    chk("post_latency", done_at - er_at, 523);
    chk("post_sb_empty", sb.size(), 0);

    // 3x4 sweep with a full 256-step ramp
    sel = 1'b1;
    b_rst = 1'b0;
    cyc();
    set_rows_b(32'hD3C2B1A0, 32'h97867564, 32'h1F2E3D4C);
    clr();
    b_start = 1'b1; cyc(); b_start = 1'b0;
    wait_done(1000);
    chk("sw_erase", n_er, 1);
    chk("sw_expose", n_ex, 1);
    chk("sw_ramp", n_ramp, 256);
    chk("sw_count_seq", bad_cnt, 0);
    chk("sw_count_max", max_cnt, 255);
    chk("sw_read_seq", rdsig, 32'h112244);
    chk("sw_latency", done_at - er_at, 276);
    chk("sw_exclusive", bad_excl, 0);
    chk("sw_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
